// File: rtl/alu_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_execute_stage
//  Description : x86-64 execute stage. Size-aware ALU (ADD/SUB/CMP/AND/OR/
//                XOR/MOV/SHL/SHR) with arithmetic flags and one register
//                stage towards write-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_opr,
  input  logic [1:0]  in_size,
  input  logic [63:0] in_opd1,
  input  logic [63:0] in_opd2,
  input  logic [3:0]  in_dest_reg,
  output logic        out_valid,
  output logic        out_we,
  output logic [3:0]  out_dest_reg,
  output logic [63:0] out_res,
  output logic [3:0]  out_flags
);

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h29;
  localparam logic [7:0] OP_CMP = 8'h39;
  localparam logic [7:0] OP_AND = 8'h21;
  localparam logic [7:0] OP_OR  = 8'h09;
  localparam logic [7:0] OP_XOR = 8'h31;
  localparam logic [7:0] OP_MOV = 8'h89;
  localparam logic [7:0] OP_SHL = 8'hE0;
  localparam logic [7:0] OP_SHR = 8'hE8;

  logic [63:0] w_mask;       // ones over the low N bits
  logic [63:0] w_msb;        // single bit at position N-1
  logic [63:0] w_a;
  logic [63:0] w_b;
  logic [5:0]  w_cnt;
  logic [5:0]  w_cnt_m1;
  logic [64:0] w_sum;
  logic [63:0] w_diff;
  logic [64:0] w_shl;
  logic [63:0] w_res_n;
  logic [63:0] w_res_full;
  logic        w_cf;
  logic        w_of;
  logic        w_sa;
  logic        w_sb;
  logic        w_sr;
  logic        w_upd_flags;
  logic        w_we;
  logic        w_defined;

  // Size decode, N-bit compute, flag generation and 64-bit merge
  always_comb begin
    w_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    w_msb  = 64'h8000_0000_0000_0000;
    case (in_size)
      2'd0: begin w_mask = 64'h0000_0000_0000_00FF; w_msb = 64'h0000_0000_0000_0080; end
      2'd1: begin w_mask = 64'h0000_0000_0000_FFFF; w_msb = 64'h0000_0000_0000_8000; end
      2'd2: begin w_mask = 64'h0000_0000_FFFF_FFFF; w_msb = 64'h0000_0000_8000_0000; end
      default: begin w_mask = 64'hFFFF_FFFF_FFFF_FFFF; w_msb = 64'h8000_0000_0000_0000; end
    endcase

    w_a      = in_opd1 & w_mask;
    w_b      = in_opd2 & w_mask;
    w_cnt    = (in_size == 2'd3) ? in_opd2[5:0] : {1'b0, in_opd2[4:0]};
    w_cnt_m1 = w_cnt - 6'd1;

    w_sum  = {1'b0, w_a} + {1'b0, w_b};
    w_diff = (w_a - w_b) & w_mask;
    // Operands are pre-masked, so bit N of the widened shift is the last bit out
    w_shl  = {1'b0, w_a} << w_cnt;

    w_sa = |(w_a & w_msb);
    w_sb = |(w_b & w_msb);

    w_res_n     = 64'd0;
    w_cf        = 1'b0;
    w_of        = 1'b0;
    w_upd_flags = 1'b1;
    w_we        = 1'b1;
    w_defined   = 1'b1;

    case (in_opr)
      OP_ADD: begin
        w_res_n = w_sum[63:0] & w_mask;
        w_cf    = |(w_sum & ~{1'b0, w_mask});
      end
      OP_SUB, OP_CMP: begin
        w_res_n = w_diff;
        w_cf    = (w_a < w_b);
        w_we    = (in_opr == OP_SUB);
      end
      OP_AND: w_res_n = w_a & w_b;
      OP_OR:  w_res_n = w_a | w_b;
      OP_XOR: w_res_n = w_a ^ w_b;
      OP_MOV: begin
        w_res_n     = w_b;
        w_upd_flags = 1'b0;
      end
      OP_SHL: begin
        w_res_n     = w_shl[63:0] & w_mask;
        w_cf        = |(w_shl & {w_msb, 1'b0});
        w_upd_flags = (w_cnt != 6'd0);
      end
      OP_SHR: begin
        w_res_n     = w_a >> w_cnt;
        w_cf        = w_a[w_cnt_m1];
        w_upd_flags = (w_cnt != 6'd0);
      end
      default: begin
        w_upd_flags = 1'b0;
        w_we        = 1'b0;
        w_defined   = 1'b0;
      end
    endcase

    w_sr = |(w_res_n & w_msb);
    if (in_opr == OP_ADD) begin
      w_of = (w_sa == w_sb) && (w_sr != w_sa);
    end else if ((in_opr == OP_SUB) || (in_opr == OP_CMP)) begin
      w_of = (w_sa != w_sb) && (w_sr != w_sa);
    end

    // 32-bit results zero-extend; 8/16-bit results keep the old upper bits
    case (in_size)
      2'd3:    w_res_full = w_res_n;
      2'd2:    w_res_full = {32'd0, w_res_n[31:0]};
      default: w_res_full = (in_opd1 & ~w_mask) | w_res_n;
    endcase
  end

  // Output register stage and architectural flags register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_we       <= 1'b0;
      out_dest_reg <= 4'd0;
      out_res      <= 64'd0;
      out_flags    <= 4'd0;
    end else if (in_valid) begin
      out_valid    <= 1'b1;
      out_we       <= w_we;
      out_dest_reg <= in_dest_reg;
      out_res      <= w_defined ? w_res_full : 64'd0;
      if (w_upd_flags) begin
        out_flags <= {w_of, w_sr, (w_res_n == 64'd0), w_cf};
      end
    end else begin
      out_valid <= 1'b0;
      out_we    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_execute_stage
//  Description : Self-checking bench for alu_execute_stage: directed cases
//                followed by random operations against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_execute_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_opr = 8'h00;
  logic [1:0]  in_size = 2'd0;
  logic [63:0] in_opd1 = 64'd0;
  logic [63:0] in_opd2 = 64'd0;
  logic [3:0]  in_dest_reg = 4'd0;
  logic        out_valid;
  logic        out_we;
  logic [3:0]  out_dest_reg;
  logic [63:0] out_res;
  logic [3:0]  out_flags;

  int errors = 0;
  int checks = 0;

  // Reference state (what the outputs should show)
  logic        m_valid = 1'b0;
  logic        m_we = 1'b0;
  logic [3:0]  m_dest = 4'd0;
  logic [63:0] m_res = 64'd0;
  logic        m_res_known = 1'b1;
  logic [3:0]  m_flags = 4'd0;

  alu_execute_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_opr       (in_opr),
    .in_size      (in_size),
    .in_opd1      (in_opd1),
    .in_opd2      (in_opd2),
    .in_dest_reg  (in_dest_reg),
    .out_valid    (out_valid),
    .out_we       (out_we),
    .out_dest_reg (out_dest_reg),
    .out_res      (out_res),
    .out_flags    (out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, m_valid});
    check({tag, ".we"},    {63'd0, out_we},    {63'd0, m_we});
    check({tag, ".flags"}, {60'd0, out_flags}, {60'd0, m_flags});
    if (m_valid) check({tag, ".dest"}, {60'd0, out_dest_reg}, {60'd0, m_dest});
    if (m_res_known) check({tag, ".res"}, out_res, m_res);
  endtask

  // Arithmetic model: N-bit values held in 128 bits, flags from signed ranges
  task automatic model(input logic v, input logic [7:0] op, input logic [1:0] sz,
                       input logic [63:0] a64, input logic [63:0] b64, input logic [3:0] d);
    int n;
    int cnt;
    logic [127:0] mask, a, b, r;
    logic signed [127:0] sa, sb, t, smax, smin;
    logic cf, of, upd, we, def;
    if (!v) begin
      m_valid = 1'b0;
      m_we    = 1'b0;
      return;
    end
    n    = 8 << sz;
    mask = (128'd1 << n) - 128'd1;
    a    = {64'd0, a64} & mask;
    b    = {64'd0, b64} & mask;
    sa   = a;
    sb   = b;
    if (((a >> (n - 1)) & 128'd1) != 0) sa = sa - (128'sd1 <<< n);
    if (((b >> (n - 1)) & 128'd1) != 0) sb = sb - (128'sd1 <<< n);
    smax = (128'sd1 <<< (n - 1)) - 128'sd1;
    smin = -(128'sd1 <<< (n - 1));
    cnt  = (sz == 2'd3) ? int'(b64[5:0]) : int'(b64[4:0]);
    r = 0; cf = 0; of = 0; upd = 1; we = 1; def = 1;
    case (op)
      8'h01: begin
        r  = a + b;
        cf = ((r >> n) & 128'd1) != 0;
        r  = r & mask;
        t  = sa + sb;
        of = (t > smax) || (t < smin);
      end
      8'h29, 8'h39: begin
        r  = (a - b) & mask;
        cf = a < b;
        t  = sa - sb;
        of = (t > smax) || (t < smin);
        we = (op == 8'h29);
      end
      8'h21: r = a & b;
      8'h09: r = a | b;
      8'h31: r = a ^ b;
      8'h89: begin r = b; upd = 0; end
      8'hE0: begin
        r = a;
        if (cnt == 0) upd = 0;
        for (int i = 0; i < cnt; i++) begin
          cf = ((r >> (n - 1)) & 128'd1) != 0;
          r  = (r << 1) & mask;
        end
      end
      8'hE8: begin
        r = a;
        if (cnt == 0) upd = 0;
        for (int i = 0; i < cnt; i++) begin
          cf = (r & 128'd1) != 0;
          r  = r >> 1;
        end
      end
      default: begin upd = 0; we = 0; def = 0; end
    endcase
    m_valid     = 1'b1;
    m_we        = we;
    m_dest      = d;
    m_res_known = def && we || !def;
    if (!def) m_res = 64'd0;
    else if (sz >= 2'd2) m_res = r[63:0];
    else m_res = (a64 & ~mask[63:0]) | r[63:0];
    if (upd) m_flags = {of, ((r >> (n - 1)) & 128'd1) != 0, r == 0, cf};
  endtask

  // Present one operation, clock it in and compare after the edge
  task automatic step(input string tag, input logic v, input logic [7:0] op, input logic [1:0] sz,
                      input logic [63:0] a, input logic [63:0] b, input logic [3:0] d);
    in_valid = v; in_opr = op; in_size = sz; in_opd1 = a; in_opd2 = b; in_dest_reg = d;
    @(posedge clk);
    model(v, op, sz, a, b, d);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_dest = 0; m_res = 0; m_res_known = 1; m_flags = 0;
  endtask

  logic [7:0] ops [10] = '{8'h01, 8'h29, 8'h39, 8'h21, 8'h09, 8'h31, 8'h89, 8'hE0, 8'hE8, 8'h00};

  initial begin
    // Asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("reset0");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    step("add_5_7", 1, 8'h01, 2'd3, 64'd5, 64'd7, 4'd3);
    check("add_5_7.lit", out_res, 64'd12);
    check("add_5_7.flit", {60'd0, out_flags}, 64'h0);
    step("add_wrap", 1, 8'h01, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd1);
    check("add_wrap.flit", {60'd0, out_flags}, 64'h3);
    step("add_ovf", 1, 8'h01, 2'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd2);
    check("add_ovf.flit", {60'd0, out_flags}, 64'hC);
    step("mov8", 1, 8'h89, 2'd0, 64'h1122_3344_5566_7788, 64'hAB, 4'd4);
    check("mov8.lit", out_res, 64'h1122_3344_5566_77AB);
    step("mov32", 1, 8'h89, 2'd2, 64'h1122_3344_5566_7788, 64'hDEAD_BEEF, 4'd5);
    check("mov32.lit", out_res, 64'h0000_0000_DEAD_BEEF);
    step("cmp", 1, 8'h39, 2'd3, 64'd3, 64'd5, 4'd6);
    check("cmp.flit", {60'd0, out_flags}, 64'h5);
    step("sub", 1, 8'h29, 2'd3, 64'd5, 64'd5, 4'd7);
    check("sub.flit", {60'd0, out_flags}, 64'h2);
    step("shl32", 1, 8'hE0, 2'd2, 64'h8000_0001, 64'd33, 4'd8);
    check("shl32.lit", out_res, 64'd2);
    step("shr0", 1, 8'hE8, 2'd3, 64'h1234_5678_9ABC_DEF0, 64'd0, 4'd9);
    step("shl8", 1, 8'hE0, 2'd0, 64'hFFFF_0000_0000_00C3, 64'd2, 4'd10);
    step("shr16", 1, 8'hE8, 2'd1, 64'hAAAA_0000_0000_8001, 64'd1, 4'd11);
    step("sub8", 1, 8'h29, 2'd0, 64'h80, 64'h01, 4'd12);
    step("undef", 1, 8'h00, 2'd3, 64'd99, 64'd1, 4'd13);
    step("idle", 0, 8'h01, 2'd3, 64'd1, 64'd1, 4'd14);
    for (int i = 0; i < 4; i++)
      step("stream", 1, 8'h01, 2'd3, 64'(i * 100), 64'(i + 1), 4'(i));

    // Reset between edges, and an op present while reset is held is discarded
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_mid");
    in_valid = 1; in_opr = 8'h01; in_size = 2'd3; in_opd1 = 64'd1; in_opd2 = 64'd2; in_dest_reg = 4'd5;
    @(posedge clk); #1;
    check_all("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    step("after_reset", 1, 8'h31, 2'd1, 64'hFFFF_FFFF_FFFF_0F0F, 64'h00FF, 4'd15);

    for (int i = 0; i < 400; i++) begin
      logic [7:0]  op;
      logic [63:0] a, b;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 19) == 0) op = 8'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 70));
      step("rand", ($urandom_range(0, 7) != 0), op, 2'($urandom_range(0, 3)), a, b, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
